// File: rtl/state_sequence_monitor_if.sv
// Bundle of the sampled state-code input, its qualifiers and the monitor's status outputs.
// master drives the samples; slave is the monitor.
interface state_sequence_monitor_if #(
    parameter int COUNT_WIDTH = 8,
    parameter int ERR_WIDTH   = 4
);
    logic                   enable;
    logic [1:0]             state;
    logic                   clear;
    logic [3:0]             phase_onehot;
    logic                   locked;
    logic                   wrap_pulse;
    logic [COUNT_WIDTH-1:0] cycle_count;
    logic                   seq_error;
    logic                   error_sticky;
    logic [ERR_WIDTH-1:0]   error_count;

    modport master (
        output enable, state, clear,
        input  phase_onehot, locked, wrap_pulse, cycle_count,
               seq_error, error_sticky, error_count
    );

    modport slave (
        input  enable, state, clear,
        output phase_onehot, locked, wrap_pulse, cycle_count,
               seq_error, error_sticky, error_count
    );
endinterface

// File: rtl/state_sequence_monitor.sv
// Checks that a 2-bit cyclic state code advances by exactly one step per enabled sample,
// locks onto a clean sequence, counts completed cycles and records sequence faults.
// Sample protocol: a sample is taken on each rising clock edge where enable=1; there is no
// backpressure. The locked output is the FSM state (1 = LOCKED, 0 = SEARCH).
module state_sequence_monitor #(
    parameter int COUNT_WIDTH    = 8,
    parameter int ERR_WIDTH      = 4,
    parameter int LOCK_THRESHOLD = 2
) (
    input logic                   clock,
    input logic                   reset_n,
    state_sequence_monitor_if.slave mon_if
);
    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} fsm_t;

    fsm_t                   fsm_q;
    logic [1:0]             prev_state_q;
    logic                   prev_valid_q;
    logic [2:0]             good_cnt_q;
    logic [3:0]             phase_q;
    logic                   wrap_q;
    logic [COUNT_WIDTH-1:0] cycle_q;
    logic                   seq_err_q;
    logic                   sticky_q;
    logic [ERR_WIDTH-1:0]   err_cnt_q;

    logic                   checked;
    logic                   legal;
    logic                   wrap_step;
    logic [2:0]             good_cnt_d;
    logic [ERR_WIDTH-1:0]   err_cnt_d;

    // 2-bit addition wraps naturally, so 3->0 counts as a legal successor.
    assign checked    = mon_if.enable && prev_valid_q;
    assign legal      = (mon_if.state == 2'(prev_state_q + 2'd1));
    assign wrap_step  = (prev_state_q == 2'd3) && (mon_if.state == 2'd0);
    assign good_cnt_d = good_cnt_q + 3'd1;
    assign err_cnt_d  = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q        <= SEARCH;
            prev_state_q <= 2'd0;
            prev_valid_q <= 1'b0;
            good_cnt_q   <= 3'd0;
            phase_q      <= 4'd0;
            wrap_q       <= 1'b0;
            cycle_q      <= '0;
            seq_err_q    <= 1'b0;
            sticky_q     <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            wrap_q    <= 1'b0;
            seq_err_q <= 1'b0;
            if (mon_if.enable) begin
                prev_state_q <= mon_if.state;
                prev_valid_q <= 1'b1;
                phase_q      <= 4'b0001 << mon_if.state;
            end else begin
                prev_valid_q <= 1'b0;
                phase_q      <= 4'd0;
            end

            if (checked) begin
                case (fsm_q)
                    SEARCH: begin
                        if (!legal) begin
                            good_cnt_q <= 3'd0;
                        end else if (good_cnt_d == 3'(LOCK_THRESHOLD)) begin
                            fsm_q      <= LOCKED;
                            good_cnt_q <= 3'd0;
                        end else begin
                            good_cnt_q <= good_cnt_d;
                        end
                    end
                    LOCKED: begin
                        if (legal) begin
                            if (wrap_step) begin
                                cycle_q <= cycle_q + 1'b1;
                                wrap_q  <= 1'b1;
                            end
                        end else begin
                            seq_err_q  <= 1'b1;
                            sticky_q   <= 1'b1;
                            err_cnt_q  <= err_cnt_d;
                            fsm_q      <= SEARCH;
                            good_cnt_q <= 3'd0;
                        end
                    end
                    default: fsm_q <= SEARCH;
                endcase
            end

            // Clear wins over any same-edge increment; the pulses are left alone.
            if (mon_if.clear) begin
                cycle_q   <= '0;
                err_cnt_q <= '0;
                sticky_q  <= 1'b0;
            end
        end
    end

    assign mon_if.phase_onehot = phase_q;
    assign mon_if.locked       = (fsm_q == LOCKED);
    assign mon_if.wrap_pulse   = wrap_q;
    assign mon_if.cycle_count  = cycle_q;
    assign mon_if.seq_error    = seq_err_q;
    assign mon_if.error_sticky = sticky_q;
    assign mon_if.error_count  = err_cnt_q;
endmodule
